pwm_ramp_ctrl: RTL and testbench

Duty-cycle sequencer for the team's counter/compare PWM generator. On a start command it ramps the PWM duty from a low level up to a high level in programmable steps, holds, then ramps back down and reports completion. Duty changes only at PWM period boundaries, so no output pulse is ever truncated or glitched. Used for LED fades, soft-start of motor drives, and similar actuator profiles.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_core.sv | 31 +++
 rtl/pwm_ramp_ctrl.sv | 148 ++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp sequencer: state encoding and default widths.
package pwm_pkg;

  localparam int N_DEF  = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_HOLD = 3'd3,
    S_DOWN = 3'd4
  } state_e;

endpackage

// File: rtl/pwm_core.sv
// Free-running PWM counter with period tick and registered duty compare.
module pwm_core #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] duty,
  output logic         pwm_out,
  output logic         tick
);

  localparam logic [N-1:0] L_ONE = N'(1);

  logic [N-1:0] r_cnt;
  logic         r_pwm;

  // Counter wraps naturally; output is high while cnt < duty, one cycle late.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_pwm <= 1'b0;
    end else begin
      r_cnt <= r_cnt + L_ONE;
      r_pwm <= (r_cnt < duty);
    end
  end

  assign tick    = (r_cnt == '1);
  assign pwm_out = r_pwm;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty-cycle ramp sequencer: up from duty_lo to duty_hi, hold, back down.
// All duty updates land on the period tick so no PWM pulse is truncated;
// stop is the only exception and forces the output off immediately.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stop,
  input  logic [N-1:0]  duty_lo,
  input  logic [N-1:0]  duty_hi,
  input  logic [N-1:0]  step,
  input  logic [DW-1:0] dwell,
  output logic          pwm_out,
  output logic [N-1:0]  duty_cur,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [N-1:0]  L_STEP1 = N'(1);
  localparam logic [DW-1:0] L_DONE  = DW'(1);

  state_e        r_state;
  logic [N-1:0]  r_lo, r_hi, r_step, r_duty;
  logic [DW-1:0] r_dwell, r_dwell_cnt;
  logic          r_busy, r_done, r_err;

  logic          w_tick;
  logic          w_dwell_hit;
  logic [N:0]    w_up_sum, w_dn_diff;
  logic [N-1:0]  w_up_nxt, w_dn_nxt;

  // Extra carry/borrow bit keeps the ramp from wrapping past either rail.
  assign w_up_sum    = {1'b0, r_duty} + {1'b0, r_step};
  assign w_dn_diff   = {1'b0, r_duty} - {1'b0, r_step};
  assign w_up_nxt    = (w_up_sum > {1'b0, r_hi}) ? r_hi : w_up_sum[N-1:0];
  assign w_dn_nxt    = (w_dn_diff[N] || (w_dn_diff[N-1:0] < r_lo)) ? r_lo : w_dn_diff[N-1:0];
  assign w_dwell_hit = (r_dwell_cnt == r_dwell);

  pwm_core #(.N(N)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .duty    (r_duty),
    .pwm_out (pwm_out),
    .tick    (w_tick)
  );

  // Sequencer FSM with config latches, dwell counter and registered status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_lo        <= '0;
      r_hi        <= '0;
      r_step      <= '0;
      r_dwell     <= '0;
      r_dwell_cnt <= '0;
      r_duty      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (stop) begin
        // Emergency off: not tick aligned, beats any simultaneous start.
        r_state     <= S_IDLE;
        r_duty      <= '0;
        r_dwell_cnt <= '0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (duty_lo < duty_hi) begin
                r_lo    <= duty_lo;
                r_hi    <= duty_hi;
                r_step  <= (step == '0) ? L_STEP1 : step;
                r_dwell <= dwell;
                r_busy  <= 1'b1;
                r_state <= S_LOAD;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            if (w_tick) begin
              r_duty      <= r_lo;
              r_dwell_cnt <= '0;
              r_state     <= S_UP;
            end
          end
          S_UP: begin
            if (w_tick) begin
              if (w_dwell_hit) begin
                r_duty      <= w_up_nxt;
                r_dwell_cnt <= '0;
                if (w_up_nxt == r_hi) r_state <= S_HOLD;
              end else begin
                r_dwell_cnt <= r_dwell_cnt + L_DONE;
              end
            end
          end
          S_HOLD: begin
            if (w_tick) begin
              if (w_dwell_hit) begin
                r_dwell_cnt <= '0;
                r_state     <= S_DOWN;
              end else begin
                r_dwell_cnt <= r_dwell_cnt + L_DONE;
              end
            end
          end
          S_DOWN: begin
            if (w_tick) begin
              if (w_dwell_hit) begin
                r_duty      <= w_dn_nxt;
                r_dwell_cnt <= '0;
                if (w_dn_nxt == r_lo) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end
              end else begin
                r_dwell_cnt <= r_dwell_cnt + L_DONE;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign duty_cur = r_duty;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: a 4-bit and an 8-bit instance.
// Stimulus pushes hand-computed per-period expectations; the monitor pops
// one entry at each period start and also counts pwm_out highs per period.
module tb_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start4, stop4, start8, stop8;
  logic [7:0] lo, hi, stp, dw;

  logic       pwm4, busy4, done4, err4;
  logic [3:0] d4;
  logic       pwm8, busy8, done8, err8;
  logic [7:0] d8;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(.N(4), .DW(8)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .stop(stop4),
    .duty_lo(lo[3:0]), .duty_hi(hi[3:0]), .step(stp[3:0]), .dwell(dw),
    .pwm_out(pwm4), .duty_cur(d4), .busy(busy4), .done(done4), .err(err4)
  );

  pwm_ramp_ctrl #(.N(8), .DW(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .stop(stop8),
    .duty_lo(lo), .duty_hi(hi), .step(stp), .dwell(dw),
    .pwm_out(pwm8), .duty_cur(d8), .busy(busy8), .done(done8), .err(err8)
  );

  // Bench-side period position, independent of the DUT.
  logic [3:0] cnt4;
  logic [7:0] cnt8;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt4 <= '0;
      cnt8 <= '0;
    end else begin
      cnt4 <= cnt4 + 4'd1;
      cnt8 <= cnt8 + 8'd1;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int ch;
    int duty;
    int done;
    int busy;
  } exp_t;

  exp_t q[$];
  int   prev_duty[2];
  bit   prev_v[2];
  int   acc[2];

  // Monitor: per channel, at each cnt==0 close the previous period's pwm
  // count and pop the expectation for the period that is starting.
  always @(negedge clk) begin : mon
    int   cn, du, pw, dn, bz;
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      cn = (c == 0) ? int'(cnt4)  : int'(cnt8);
      du = (c == 0) ? int'(d4)    : int'(d8);
      pw = (c == 0) ? int'(pwm4)  : int'(pwm8);
      dn = (c == 0) ? int'(done4) : int'(done8);
      bz = (c == 0) ? int'(busy4) : int'(busy8);
      if (!reset_n) begin
        prev_v[c] = 1'b0;
        acc[c]    = 0;
      end else begin
        acc[c] += pw;
        if (cn == 0) begin
          if (prev_v[c]) check($sformatf("pwm_high_cycles[ch%0d]", c), acc[c], prev_duty[c]);
          acc[c]    = 0;
          prev_v[c] = 1'b0;
          if (q.size() > 0 && q[0].ch == c) begin
            e = q.pop_front();
            check($sformatf("duty_cur[ch%0d]", c), du, e.duty);
            check($sformatf("done[ch%0d]", c), dn, e.done);
            check($sformatf("busy[ch%0d]", c), bz, e.busy);
            prev_duty[c] = e.duty;
            prev_v[c]    = 1'b1;
          end
        end
      end
    end
  end

  task automatic push(input int c, input int d, input int dn, input int b);
    exp_t e;
    e.ch = c; e.duty = d; e.done = dn; e.busy = b;
    q.push_back(e);
  endtask

  task automatic push_n(input int c, input int d, input int n);
    for (int i = 0; i < n; i++) push(c, d, 0, 1);
  endtask

  task automatic wait_cnt(input int c, input int v);
    bit hit = 1'b0;
    for (int k = 0; k < 600 && !hit; k++) begin
      @(negedge clk);
      if (((c == 0) ? int'(cnt4) : int'(cnt8)) == v) hit = 1'b1;
    end
    if (!hit) check("wait_cnt_timeout", 1, 0);
  endtask

  // Issue a start at cnt==3; returns at the following negedge (state LOAD).
  task automatic start_prof(input int c, input int l, input int h, input int s, input int d);
    wait_cnt(c, 3);
    lo = 8'(l); hi = 8'(h); stp = 8'(s); dw = 8'(d);
    if (c == 0) start4 = 1'b1; else start8 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    start8 = 1'b0;
    check($sformatf("busy_after_start[ch%0d]", c), (c == 0) ? int'(busy4) : int'(busy8), 1);
  endtask

  task automatic drain(input int c);
    bit fin = 1'b0;
    for (int k = 0; k < 6000 && !fin; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !prev_v[c]) fin = 1'b1;
    end
    if (!fin) check("drain_timeout", 1, 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit seen;
    reset_n = 1'b0;
    start4 = 1'b0; stop4 = 1'b0; start8 = 1'b0; stop8 = 1'b0;
    lo = '0; hi = '0; stp = '0; dw = '0;
    repeat (3) @(negedge clk);
    check("rst_duty4", d4, 0);
    check("rst_pwm4", pwm4, 0);
    check("rst_busy4", busy4, 0);
    check("rst_done4", done4, 0);
    check("rst_err4", err4, 0);
    check("rst_duty8", d8, 0);
    reset_n = 1'b1;

    // Reset asserted mid-ramp clears outputs without a clock edge.
    start_prof(0, 2, 10, 3, 0);
    repeat (40) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_duty4", d4, 0);
    check("midrst_pwm4", pwm4, 0);
    check("midrst_busy4", busy4, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic ramp; period alignment also proves cnt restarted at 0.
    start_prof(0, 2, 10, 3, 0);
    push(0, 2, 0, 1); push(0, 5, 0, 1); push(0, 8, 0, 1); push(0, 10, 0, 1);
    push(0, 10, 0, 1); push(0, 7, 0, 1); push(0, 4, 0, 1);
    push(0, 2, 1, 0); push(0, 2, 0, 0);
    drain(0);

    // Dwell 2: every level lasts 3 periods; mid-profile bad start is ignored.
    start_prof(0, 0, 4, 2, 2);
    push_n(0, 0, 3); push_n(0, 2, 3); push_n(0, 4, 6); push_n(0, 2, 3);
    push(0, 0, 1, 0); push(0, 0, 0, 0);
    repeat (40) @(negedge clk);
    lo = 8'd9; hi = 8'd9; stp = 8'd1; dw = 8'd0;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("busy_start_no_err", err4, 0);
    check("busy_start_still_busy", busy4, 1);
    drain(0);

    // lo == hi is rejected with a one-cycle err.
    @(negedge clk);
    lo = 8'd8; hi = 8'd8; stp = 8'd1; dw = 8'd0;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("badcfg_err", err4, 1);
    check("badcfg_busy", busy4, 0);
    @(negedge clk);
    check("badcfg_err_clear", err4, 0);
    check("badcfg_busy_later", busy4, 0);

    // step 0 behaves as step 1.
    start_prof(0, 1, 3, 0, 0);
    push(0, 1, 0, 1); push(0, 2, 0, 1); push(0, 3, 0, 1); push(0, 3, 0, 1);
    push(0, 2, 0, 1); push(0, 1, 1, 0); push(0, 1, 0, 0);
    drain(0);

    // stop in UP at cnt 5 while duty is 8.
    start_prof(0, 2, 10, 3, 0);
    wait_cnt(0, 0); wait_cnt(0, 0); wait_cnt(0, 0);
    wait_cnt(0, 5);
    check("pre_stop_duty", d4, 8);
    stop4 = 1'b1;
    @(negedge clk);
    stop4 = 1'b0;
    check("stop_duty", d4, 0);
    check("stop_busy", busy4, 0);
    check("stop_pwm_lag", pwm4, 1);
    @(negedge clk);
    check("stop_pwm_off", pwm4, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done4) seen = 1'b1;
    end
    check("stop_no_done", seen, 0);

    // stop and start together: stop wins.
    lo = 8'd2; hi = 8'd10; stp = 8'd3; dw = 8'd0;
    start4 = 1'b1; stop4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; stop4 = 1'b0;
    check("collide_busy", busy4, 0);
    repeat (20) @(negedge clk);
    check("collide_busy_later", busy4, 0);
    check("collide_duty", d4, 0);

    // 8-bit saturation at both rails.
    start_prof(1, 250, 255, 10, 0);
    push(1, 250, 0, 1); push(1, 255, 0, 1); push(1, 255, 0, 1);
    push(1, 250, 1, 0); push(1, 250, 0, 0);
    drain(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
